// File: rtl/mul_check_pkg.sv
// Shared helpers for the array multiply-add checker: pipeline mask and beat layout width.
package mul_check_pkg;

    // Upper bound on DATAWIDTH+1 supported by the mask helper.
    localparam int MAX_MASK_W = 128;

    // Beat carried across a boundary: {acc(2W), Q(W), B(W), A_exp(W), r_ge_b flag, valid}.
    function automatic int beat_width(input int dw);
        return 2*dw + 3*dw + 2;
    endfunction

    // Boundary k is registered when k < n; boundaries 0..dw exist.
    function automatic logic [MAX_MASK_W-1:0] pipe_mask(input int dw, input int n);
        logic [MAX_MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_MASK_W; i++) begin
            if (i <= dw && i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/mul_pipe_reg.sv
// Optional pipeline boundary: a reset-to-zero register when enabled, a plain wire otherwise.
module mul_pipe_reg #(
    parameter int WIDTH  = 1,
    parameter bit ENABLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (ENABLE) begin : g_reg
        // Capture the beat each cycle; async clear drops anything in flight.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) q <= '0;
            else        q <= d;
        end
    end else begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign q = d;
    end

endmodule

// File: rtl/mul_row_comb.sv
// One combinational row of the array multiplier: adds B<<ROW when this Q bit is set.
module mul_row_comb #(
    parameter int DATAWIDTH = 8,
    parameter int ROW       = 0
) (
    input  logic [2*DATAWIDTH-1:0] acc_in,
    input  logic                   q_bit,
    input  logic [DATAWIDTH-1:0]   b,
    output logic [2*DATAWIDTH-1:0] acc_out
);

    logic [2*DATAWIDTH-1:0] pp;

    // Partial product is B shifted to this row's weight, gated by the quotient bit.
    assign pp      = q_bit ? ({{DATAWIDTH{1'b0}}, b} << ROW) : '0;
    assign acc_out = acc_in + pp;

endmodule

// File: rtl/array_mul_checker.sv
// Pipelined P = Q*B + R that rebuilds the divider's dividend and flags beats that disagree.
module array_mul_checker
    import mul_check_pkg::*;
#(
    parameter int DATAWIDTH           = 8,
    parameter int NUM_PIPELINE_STAGES = 1,
    parameter int ERR_CNT_WIDTH       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic [DATAWIDTH-1:0]     Q,
    input  logic [DATAWIDTH-1:0]     B,
    input  logic [DATAWIDTH-1:0]     R,
    input  logic [DATAWIDTH-1:0]     A_exp,
    output logic                     o_valid,
    output logic [2*DATAWIDTH-1:0]   P_out,
    output logic                     o_mismatch,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam int W      = DATAWIDTH;
    localparam int AW     = 2*W;
    localparam int BEAT_W = beat_width(W);
    localparam logic [MAX_MASK_W-1:0] MASK = pipe_mask(W, NUM_PIPELINE_STAGES);

    // Field offsets inside a beat.
    localparam int V_O   = 0;
    localparam int F_O   = 1;
    localparam int A_O   = 2;
    localparam int B_O   = 2 + W;
    localparam int Q_O   = 2 + 2*W;
    localparam int ACC_O = 2 + 3*W;

    logic [W:0][BEAT_W-1:0]   row_in;   // beat arriving at boundary k
    logic [W-1:0][BEAT_W-1:0] row_q;    // beat leaving boundary k into row k
    logic [W-1:0][AW-1:0]     acc_nxt;
    logic                     r_ge_b;

    // R >= B only matters for a real divisor; resolved at entry and carried with the beat.
    assign r_ge_b    = (B != '0) && (R >= B);
    assign row_in[0] = {{W{1'b0}}, R, Q, B, A_exp, r_ge_b, i_valid};

    for (genvar k = 0; k < W; k++) begin : g_row
        mul_pipe_reg #(.WIDTH(BEAT_W), .ENABLE(MASK[k])) u_bnd (
            .clk   (clk),
            .rst_n (rst),
            .d     (row_in[k]),
            .q     (row_q[k])
        );

        mul_row_comb #(.DATAWIDTH(W), .ROW(k)) u_row (
            .acc_in  (row_q[k][ACC_O +: AW]),
            .q_bit   (row_q[k][Q_O + k]),
            .b       (row_q[k][B_O +: W]),
            .acc_out (acc_nxt[k])
        );

        assign row_in[k+1] = {acc_nxt[k], row_q[k][ACC_O-1:0]};
    end

    // Compare against the original dividend, then the final boundary.
    logic [AW-1:0]   p_fin;
    logic            mis_fin;
    logic [AW+1:0]   out_d;
    logic [AW+1:0]   out_q;
    logic [2*W-1:0]  unused_qb;

    assign p_fin     = row_in[W][ACC_O +: AW];
    assign mis_fin   = (p_fin != {{W{1'b0}}, row_in[W][A_O +: W]}) || row_in[W][F_O];
    assign out_d     = {p_fin, mis_fin, row_in[W][V_O]};
    assign unused_qb = row_in[W][B_O +: 2*W];

    mul_pipe_reg #(.WIDTH(AW+2), .ENABLE(MASK[W])) u_bnd_out (
        .clk   (clk),
        .rst_n (rst),
        .d     (out_d),
        .q     (out_q)
    );

    assign P_out      = out_q[AW+1:2];
    assign o_mismatch = out_q[1];
    assign o_valid    = out_q[0];

    // Saturating count of failed beats; always registered, even with a combinational datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count <= '0;
        end else if (o_valid && o_mismatch && (err_count != '1)) begin
            err_count <= err_count + ERR_CNT_WIDTH'(1);
        end
    end

endmodule

// File: doc/array_mul_checker.md
Name: array_mul_checker

Overview:
- Pipelined unsigned array multiply-add: computes P = Q*B + R, the inverse of the team's pipelined array divider.
- Sits downstream of the divider. It rebuilds the dividend from the divider's quotient, divisor and remainder, then checks it against the original dividend carried alongside.
- The number of pipeline registers is set by a parameter, using the same pipeline-mask scheme as the divider.
- Continuous valid stream; no back-pressure.

Parameters:
- DATAWIDTH, 8, width of Q, B, R and A_exp.
- NUM_PIPELINE_STAGES, 1, number of enabled pipeline boundaries, legal range 0..DATAWIDTH+1. The low NUM_PIPELINE_STAGES bits of a (DATAWIDTH+1)-bit mask are set.
- ERR_CNT_WIDTH, 16, width of the saturating mismatch counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- i_valid  input  1  input beat valid.
- Q  input  DATAWIDTH  quotient (multiplier operand).
- B  input  DATAWIDTH  divisor (multiplicand).
- R  input  DATAWIDTH  remainder (addend).
- A_exp  input  DATAWIDTH  original dividend, compared against P.
- o_valid  output  1  output beat valid.
- P_out  output  2*DATAWIDTH  Q*B+R.
- o_mismatch  output  1  check failed for this beat; qualified by o_valid.
- err_count  output  ERR_CNT_WIDTH  saturating count of failed beats.

Behaviour:
- Row datapath, i = 0..DATAWIDTH-1:
  - acc[0] = zero-extended R.
  - acc[i+1] = acc[i] + (Q[i] ? (B << i) : 0).
  - Every accumulator is 2*DATAWIDTH bits with no truncation. The maximum result is 2^(2W) - 2^W, so no overflow is possible.
- Pipeline boundaries:
  - Boundary k (0 ≤ k < DATAWIDTH) sits before row k.
  - Boundary DATAWIDTH sits after the last row and the compare logic.
  - Each boundary carries {acc, Q, B, A_exp, B_nonzero_R_ge_B flag, valid}.
  - A disabled boundary is a wire.
  - Latency from i_valid to o_valid is exactly NUM_PIPELINE_STAGES cycles; 0 means fully combinational outputs.
- Valid propagates in order with the data; there is one result per input beat.
  - Data on beats where i_valid=0 still flows through.
  - Outputs on invalid beats are don't-care, except that o_valid=0.
- Mismatch rule: o_mismatch = (P != zero-extended A_exp) OR (B != 0 AND R >= B).
  - The R >= B flag is evaluated at the input and piped down with the beat.
- Divide-by-zero convention: the divider returns Q = all ones and R = A when B=0. Here P = R, so that beat passes provided R == A_exp. No special case is needed.
- err_count:
  - Increments by 1 on the rising edge where o_valid & o_mismatch is sampled high.
  - Holds at 2^ERR_CNT_WIDTH - 1 (saturates, never wraps).
  - In the combinational configuration (NUM_PIPELINE_STAGES=0), err_count is still registered and updates on the next edge.
- Reset while rst=0, all immediate (asynchronous):
  - All enabled boundary registers clear to 0, including valid.
  - err_count = 0.
  - o_valid = 0, P_out = 0, o_mismatch = 0, provided boundary DATAWIDTH is enabled.
- Reset mid-stream: all in-flight beats are discarded. The first o_valid after release is the beat presented NUM_PIPELINE_STAGES cycles after the first post-reset edge.
- Back-to-back valid beats on every cycle are sustained, so throughput is 1 beat per cycle.

Decomposition:
- Package mul_check_pkg holds:
  - the function computing the pipeline mask from (DATAWIDTH, NUM_PIPELINE_STAGES);
  - the localparam for beat width, 2*DATAWIDTH + 3*DATAWIDTH + 2.
- Sub-module mul_row_comb: one combinational row (acc_in, Q bit, B, ROW parameter → acc_out).
  - It is instantiated DATAWIDTH times in a generate loop.
- Boundary registers are a mul_pipe_reg sub-module with parameters WIDTH and ENABLE and an async active-low reset.

Test Plan:
- W=8, N=1, rst held low then released, one beat Q=13, B=7, R=3, A_exp=94 → o_valid exactly 1 cycle later, P_out=94, o_mismatch=0, err_count=0.
- Q=255, B=0, R=200, A_exp=200 → P_out=200, o_mismatch=0. Same beat with A_exp=201 → o_mismatch=1, err_count increments to 1 on the next edge.
- R=7, B=7, Q=1, A_exp=14 → P_out=14 but o_mismatch=1 because R>=B.
- Boundary values:
  - Q=B=R=255 → P_out=65280.
  - Q=0, R=0 → P_out=0.
- Sweep N ∈ {0,1,4,9}; stream 1000 random beats taken from the real array_divider outputs, with i_valid toggling randomly → latency equals N, order preserved, zero mismatches.
- Saturation and reset:
  - ERR_CNT_WIDTH=4, 20 consecutive mismatching beats → err_count stops at 15.
  - Assert rst mid-stream → all outputs clear immediately with no clock edge, and no stale o_valid appears after release.
